// File: rtl/dm_resp_if.sv
// Bundles the CPU-side data-memory bus and the debug read port of dm_resp.
// Purely combinational wiring; the interface adds no latency.
// No backpressure: every request is accepted in the cycle it is presented.
interface dm_resp_if #(
    parameter int ADDR_W = 10
);
    logic              mem_w;
    logic [31:0]       addr;
    logic [31:0]       din;
    logic [2:0]        digit;
    logic              err_clr;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dout;
    logic              err;
    logic [31:0]       err_addr;
    logic [31:0]       st_cnt;
    logic [31:0]       dbg_data;

    // CPU / bench side
    modport master (
        output mem_w, addr, din, digit, err_clr, dbg_addr,
        input  dout, err, err_addr, st_cnt, dbg_data
    );

    // memory side
    modport slave (
        input  mem_w, addr, din, digit, err_clr, dbg_addr,
        output dout, err, err_addr, st_cnt, dbg_data
    );
endinterface

// File: rtl/dm_resp.sv
// Word-organised data memory with byte/half/word loads+stores, sticky store-fault flag and store counter.
// Loads and debug reads are combinational (0 cycles); stores commit on the rising clk edge.
// No backpressure: faulting stores are dropped and flagged, never stalled.
module dm_resp #(
    parameter int ADDR_W = 10
) (
    input  logic      clk,
    input  logic      reset,
    dm_resp_if.slave  bus
);
    localparam logic [2:0] D_WORD   = 3'b000;
    localparam logic [2:0] D_HALF_S = 3'b001;
    localparam logic [2:0] D_HALF_U = 3'b010;
    localparam logic [2:0] D_BYTE_S = 3'b011;
    localparam logic [2:0] D_BYTE_U = 3'b100;

    logic [31:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic              acc_ok;
    logic              wr_en;
    logic              fault;
    logic [3:0]        be;
    logic [31:0]       wd;
    logic [31:0]       rd_word;
    logic [15:0]       rd_half;
    logic [7:0]        rd_byte;
    logic              addr_unused;

    // High address bits alias onto the same word.
    assign word_idx    = bus.addr[ADDR_W+1:2];
    assign lane        = bus.addr[1:0];
    assign addr_unused = ^bus.addr[31:ADDR_W+2];
    assign rd_word     = mem[word_idx];
    assign rd_half     = lane[1] ? rd_word[31:16] : rd_word[15:0];
    assign rd_byte     = rd_word[8*lane +: 8];
    assign bus.dbg_data = mem[bus.dbg_addr];

    // Access legality plus byte-enable / lane-replicated write data for the store path.
    always_comb begin
        acc_ok = 1'b0;
        be     = 4'b0000;
        wd     = bus.din;
        case (bus.digit)
            D_WORD: begin
                acc_ok = (lane == 2'b00);
                be     = 4'b1111;
            end
            D_HALF_S, D_HALF_U: begin
                acc_ok = ~lane[0];
                be     = 4'b0011 << lane;
                wd     = {2{bus.din[15:0]}};
            end
            D_BYTE_S, D_BYTE_U: begin
                acc_ok = 1'b1;
                be     = 4'b0001 << lane;
                wd     = {4{bus.din[7:0]}};
            end
            default: acc_ok = 1'b0;
        endcase
        // No commit while reset is held, even though reset leaves the array alone.
        wr_en = bus.mem_w & acc_ok & ~reset;
        fault = bus.mem_w & ~acc_ok;
    end

    // Load data, extended per access type; illegal accesses read as zero.
    always_comb begin
        bus.dout = 32'd0;
        if (acc_ok) begin
            case (bus.digit)
                D_WORD:   bus.dout = rd_word;
                D_HALF_S: bus.dout = {{16{rd_half[15]}}, rd_half};
                D_HALF_U: bus.dout = {16'd0, rd_half};
                D_BYTE_S: bus.dout = {{24{rd_byte[7]}}, rd_byte};
                D_BYTE_U: bus.dout = {24'd0, rd_byte};
                default:  bus.dout = 32'd0;
            endcase
        end
    end

    // Array write with byte enables; array contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[word_idx][8*b +: 8] <= wd[8*b +: 8];
                end
            end
        end
    end

    // Fault flag, first-fault address and store counter.
    // A clear in the same cycle as a fault makes that fault the new "first" one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.err      <= 1'b0;
            bus.err_addr <= 32'd0;
            bus.st_cnt   <= 32'd0;
        end else begin
            if (fault) begin
                bus.err <= 1'b1;
                if (!bus.err || bus.err_clr) begin
                    bus.err_addr <= bus.addr;
                end
            end else if (bus.err_clr) begin
                bus.err <= 1'b0;
            end
            if (wr_en) begin
                bus.st_cnt <= bus.st_cnt + 32'd1;
            end
        end
    end
endmodule
